maxpool2x2_stream: RTL and testbench
====================================

Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage directly downstream of the ReLU activation stage in the YOLOv7 UAV feature pipeline.
- Consumes one activation element per beat in raster order (one channel plane per frame) and emits the pooled plane.
- Uses a half-width line buffer so a full input frame is never stored.
- Valid/ready handshake on both sides; output is registered.

Parameters:
- DATAWIDTH, 8, element width; two's-complement signed.
- WIDTH, 320, input plane width in elements; must be even and >= 2.
- HEIGHT, 320, input plane height in rows; must be even and >= 2.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- en  input  1  stage enable; when low, no input is accepted and the output register holds.
- in_data  input  DATAWIDTH  activation element, signed.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  stage accepts in_data this cycle.
- out_data  output  DATAWIDTH  pooled element, signed.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  qualifies the final pooled element of a frame (with out_valid).

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, col=0, row=0, hold register=0. Line buffer contents are don't-care.
- in_ready = en && (!out_valid || out_ready). This is combinational and has no dependence on in_valid.
- Accept = in_valid && in_ready. Counters and datapath advance only on accept.
- Counters:
  - col counts 0..WIDTH-1; at WIDTH-1 it wraps to 0 and row increments.
  - row counts 0..HEIGHT-1; at HEIGHT-1 with col=WIDTH-1 both wrap to 0 and the next frame starts with no idle cycle.
- Even row (row[0]=0):
  - even col: hold <= in_data.
  - odd col: linebuf[col>>1] <= max(hold, in_data).
  - No output is produced on even rows.
- Odd row (row[0]=1):
  - even col: hold <= in_data.
  - odd col: out_data <= max(hold, in_data, linebuf[col>>1]); out_valid <= 1.
  - out_last <= 1 when row=HEIGHT-1 and col=WIDTH-1, else 0.
- All max comparisons are signed. Result width is DATAWIDTH; no saturation is needed.
- Latency: out_valid rises on the clock edge that accepts the bottom-right element of a 2x2 window, i.e. one cycle after the accepting cycle.
- Output handshake:
  - out_valid clears on out_valid && out_ready unless a new result loads on the same edge.
  - Simultaneous drain and load: the new result replaces the old one with no bubble and out_valid stays 1.
  - out_data and out_last are stable while out_valid && !out_ready.
- Throughput: one input per cycle sustained when out_ready=1; one output per four input beats.
- Outputs per frame: (WIDTH/2)*(HEIGHT/2). Exactly one out_last per frame.
- en low mid-frame: in_ready=0; counters, hold, line buffer and pending output are all retained. A pending output may still drain via out_ready.
- Reset mid-frame: counters return to 0 and any pending output is discarded. The next accepted element is treated as row 0, col 0.
- Line buffer: WIDTH/2 entries of DATAWIDTH. Single write port and single read port. The read for odd rows is issued combinationally or from registered address so that no extra cycle is added to the accept path. Reads and writes never target the same entry in the same cycle.

Test Plan:
- WIDTH=4, HEIGHT=4, out_ready=1, en=1, frame 0..15 raster -> outputs 5,7,13,15 on consecutive pool completions; out_last=1 only with 15.
- Signed data: window {-3,-128,-7,-1} -> out_data=-1 (0xFF); window {-128,-128,-128,-128} -> 0x80.
- Backpressure: out_ready=0 while the first pooled result is pending -> in_ready=0 from the next cycle, out_data=5 held stable; release out_ready -> stream resumes with no lost or duplicated outputs.
- en toggled low for 3 cycles mid-row 1 -> in_ready=0, no state change; outputs identical to the uninterrupted run.
- Back-to-back frames (32 beats, second frame values +100) -> outputs 5,7,13,15,105,107,113,115; out_last on 15 and 115.
- Assert rst after 10 accepted beats, then send a fresh frame 0..15 -> out_valid=0 immediately on assert; outputs 5,7,13,15 with no stale result.

Source files
------------

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream
//   Streaming 2x2 / stride-2 signed max-pooling stage. Elements arrive one per
//   accepted beat in raster order, one channel plane per frame. Even rows fold
//   column pairs into a half-width line buffer. Odd rows fold column pairs,
//   combine them with the buffered pair and emit one pooled element per window.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         stage enable; low blocks input, output register holds
//   in_data    signed activation element
//   in_valid   in_data valid
//   in_ready   stage accepts in_data this cycle (independent of in_valid)
//   out_data   signed pooled element (registered)
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   out_last   final pooled element of the frame (qualified by out_valid)
module maxpool2x2_stream #(
  parameter int DATAWIDTH = 8,
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 320
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam int DEPTH = WIDTH / 2;
  localparam int CW    = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
  localparam int RW    = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam int AW    = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;

  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic signed [DATAWIDTH-1:0] hold;
  logic signed [DATAWIDTH-1:0] linebuf [DEPTH];

  logic                        accept;
  logic                        col_end;
  logic                        row_end;
  logic                        lb_write;
  logic                        load;
  logic [AW-1:0]               lb_addr;
  logic signed [DATAWIDTH-1:0] din;
  logic signed [DATAWIDTH-1:0] lb_rd;
  logic signed [DATAWIDTH-1:0] pair_max;
  logic signed [DATAWIDTH-1:0] pool_max;

  function automatic logic signed [DATAWIDTH-1:0] smax(
    input logic signed [DATAWIDTH-1:0] a,
    input logic signed [DATAWIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign in_ready = en && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign col_end  = (col == COL_MAX);
  assign row_end  = (row == ROW_MAX);

  assign din      = $signed(in_data);
  assign lb_addr  = AW'(col >> 1);
  // Asynchronous read: the odd-row window completes in the same accept cycle.
  // Writes happen only on even rows and reads are used only on odd rows, so
  // the two ports never touch the same entry in one cycle.
  assign lb_rd    = linebuf[lb_addr];
  assign pair_max = smax(hold, din);
  assign pool_max = smax(pair_max, lb_rd);

  assign lb_write = accept && !row[0] && col[0];
  assign load     = accept &&  row[0] && col[0];

  // Line buffer has no reset; its contents are always written before use.
  always_ff @(posedge clk) begin
    if (lb_write) begin
      linebuf[lb_addr] <= pair_max;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (!col[0]) begin
          hold <= din;
        end
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // A load can only happen when in_ready is high, so the register is
      // either empty or being drained on this edge: no result is lost.
      if (load) begin
        out_data  <= pool_max;
        out_valid <= 1'b1;
        out_last  <= row_end && col_end;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
module tb_maxpool2x2_stream;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit rand_mode = 1'b0;

  int            acc[$];
  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];
  logic [DW-1:0] got_data[$];
  logic          got_last[$];
  logic [DW-1:0] frame_buf[N];

  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  maxpool2x2_stream #(.DATAWIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Random backpressure / enable gaps, changed just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) begin
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 4) != 0);
    end
  end

  // Reference model: gather a whole accepted frame, then pool it with plain
  // arithmetic over each 2x2 window.
  task automatic model_frame();
    int m;
    for (int r = 0; r < H / 2; r++) begin
      for (int c = 0; c < W / 2; c++) begin
        m = acc[(2 * r) * W + 2 * c];
        if (acc[(2 * r) * W + 2 * c + 1] > m)     m = acc[(2 * r) * W + 2 * c + 1];
        if (acc[(2 * r + 1) * W + 2 * c] > m)     m = acc[(2 * r + 1) * W + 2 * c];
        if (acc[(2 * r + 1) * W + 2 * c + 1] > m) m = acc[(2 * r + 1) * W + 2 * c + 1];
        exp_data.push_back(m[DW-1:0]);
        exp_last.push_back((r == H / 2 - 1) && (c == W / 2 - 1));
      end
    end
    acc.delete();
  endtask

  // Monitor at the falling edge: the handshake signals seen here are the ones
  // the next rising edge acts on.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
      continue;
    end
    if (prev_stall) begin
      n_run++;
      if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
        n_fail++;
        $display("FAIL stall_stable: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                 out_valid, out_data, out_last, prev_data, prev_last);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    if (in_valid && in_ready) begin
      acc.push_back(int'($signed(in_data)));
      if (acc.size() == N) model_frame();
    end
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
  end

  task automatic clear_queues();
    acc.delete();
    exp_data.delete();
    exp_last.delete();
    got_data.delete();
    got_last.delete();
  endtask

  task automatic send_beat(input logic [DW-1:0] v);
    bit done = 1'b0;
    in_data  = v;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (!done) begin
      n_run++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < N; i++) send_beat(frame_buf[i]);
  endtask

  task automatic drain();
    rand_mode = 1'b0;
    out_ready = 1'b1;
    en        = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    en        = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #3;
    n_run++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_run++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", out_data); end
    n_run++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last); end
    n_run++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_queues();
  endtask

  task automatic test_raster();
    logic [DW-1:0] k[4];
    k = '{8'd5, 8'd7, 8'd13, 8'd15};
    clear_queues();
    for (int i = 0; i < N; i++) frame_buf[i] = DW'(i);
    for (int i = 0; i < N; i++) begin
      send_beat(frame_buf[i]);
      if (i == 5) begin
        n_run++;
        if (out_valid !== 1'b1 || out_data !== 8'd5) begin
          n_fail++;
          $display("FAIL raster_latency: valid=%b data=%0d, required valid=1 data=5", out_valid, out_data);
        end
      end
    end
    drain();
    n_run++;
    if (got_data.size() != 4) begin
      n_fail++;
      $display("FAIL raster_count: got %0d outputs want 4", got_data.size());
    end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      n_run++;
      if (got_data[i] !== k[i] || got_last[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL raster_out[%0d]: got %0d last=%b want %0d last=%b", i, got_data[i], got_last[i], k[i], (i == 3));
      end
    end
  endtask

  task automatic test_signed();
    clear_queues();
    for (int i = 0; i < N; i++) frame_buf[i] = DW'($urandom);
    frame_buf[0] = 8'hFD; frame_buf[1] = 8'h80; frame_buf[2] = 8'h80; frame_buf[3] = 8'h80;
    frame_buf[4] = 8'hF9; frame_buf[5] = 8'hFF; frame_buf[6] = 8'h80; frame_buf[7] = 8'h80;
    send_frame();
    drain();
    n_run++;
    if (got_data.size() != exp_data.size()) begin
      n_fail++;
      $display("FAIL signed_count: got %0d want %0d", got_data.size(), exp_data.size());
    end
    if (got_data.size() >= 2) begin
      n_run++;
      if (got_data[0] !== 8'hFF) begin n_fail++; $display("FAIL signed_neg1: got %h want ff", got_data[0]); end
      n_run++;
      if (got_data[1] !== 8'h80) begin n_fail++; $display("FAIL signed_min: got %h want 80", got_data[1]); end
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      n_run++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL signed_out[%0d]: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_queues();
    for (int i = 0; i < N; i++) frame_buf[i] = DW'(i);
    out_ready = 1'b0;
    fork
      send_frame();
      begin
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
          @(negedge clk);
          if (out_valid) seen = 1'b1;
        end
        n_run++;
        if (!seen) begin n_fail++; $display("FAIL bp_wait: out_valid stayed 0, required 1"); end
        repeat (4) begin
          @(negedge clk);
          n_run++;
          if (in_ready !== 1'b0 || out_data !== 8'd5) begin
            n_fail++;
            $display("FAIL bp_hold: in_ready=%b data=%0d, required in_ready=0 data=5", in_ready, out_data);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    n_run++;
    if (got_data.size() != exp_data.size()) begin
      n_fail++;
      $display("FAIL bp_count: got %0d want %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      n_run++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL bp_out[%0d]: got %0d/%b want %0d/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_enable();
    clear_queues();
    for (int i = 0; i < N; i++) frame_buf[i] = DW'($urandom);
    fork
      send_frame();
      begin
        for (int k = 0; k < 200 && acc.size() < 6; k++) @(negedge clk);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) begin
          @(negedge clk);
          n_run++;
          if (in_ready !== 1'b0) begin n_fail++; $display("FAIL en_ready: got %b want 0", in_ready); end
        end
        @(posedge clk);
        #1;
        en = 1'b1;
      end
    join
    drain();
    n_run++;
    if (got_data.size() != exp_data.size()) begin
      n_fail++;
      $display("FAIL en_count: got %0d want %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      n_run++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL en_out[%0d]: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [DW-1:0] k[8];
    k = '{8'd5, 8'd7, 8'd13, 8'd15, 8'd105, 8'd107, 8'd113, 8'd115};
    clear_queues();
    c0 = cyc;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < N; i++) send_beat(DW'(i + 100 * f));
    n_run++;
    if (cyc - c0 != 2 * N) begin
      n_fail++;
      $display("FAIL b2b_cycles: took %0d cycles want %0d", cyc - c0, 2 * N);
    end
    drain();
    n_run++;
    if (got_data.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 8", got_data.size());
    end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      n_run++;
      if (got_data[i] !== k[i] || got_last[i] !== (i == 3 || i == 7)) begin
        n_fail++;
        $display("FAIL b2b_out[%0d]: got %0d/%b want %0d/%b", i, got_data[i], got_last[i], k[i], (i == 3 || i == 7));
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    for (int i = 0; i < 10; i++) send_beat(DW'(8'h40 + i));
    rst = 1'b1;
    #1;
    n_run++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_clear: valid=%b data=%h, required valid=0 data=00", out_valid, out_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_queues();
    for (int i = 0; i < N; i++) frame_buf[i] = DW'(i);
    send_frame();
    drain();
    n_run++;
    if (got_data.size() != 4) begin
      n_fail++;
      $display("FAIL rstmid_count: got %0d want 4", got_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      n_run++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL rstmid_out[%0d]: got %0d/%b want %0d/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_random();
    clear_queues();
    rand_mode = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) frame_buf[i] = DW'($urandom);
      send_frame();
    end
    drain();
    n_run++;
    if (got_data.size() != exp_data.size() || exp_data.size() != 6 * N / 4) begin
      n_fail++;
      $display("FAIL rand_count: got %0d want %0d", got_data.size(), 6 * N / 4);
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      n_run++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_signed();
    test_backpressure();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
